// File: rtl/nios2_cordic_cpu_oci_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios2_cordic_cpu_oci_pkg
// Brief    : Shared constants and FSM state type for the OCI compressed-trace path
// Revision : 1.0 - initial release
// ============================================================================
package nios2_cordic_cpu_oci_pkg;

    localparam int ATOM_W = 2;
    localparam int ATOMS  = 15;
    localparam int BUF_W  = ATOM_W * ATOMS;
    localparam int CNT_W  = 4;
    localparam int OVF_W  = 8;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ATOMS);
    localparam logic [OVF_W-1:0] DROP_MAX = '1;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSH     = 2'd1,
        END_FLUSH = 2'd2,
        ENDED     = 2'd3
    } dct_state_t;

endpackage
`default_nettype wire

// File: rtl/nios2_cordic_cpu_oci_dct_hold.sv
`default_nettype none
// ============================================================================
// Module   : nios2_cordic_cpu_oci_dct_hold
// Brief    : Valid/ready holding register for completed trace frames
// Revision : 1.0 - initial release
// ============================================================================
module nios2_cordic_cpu_oci_dct_hold
    import nios2_cordic_cpu_oci_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [BUF_W-1:0] load_data,
    input  logic [CNT_W-1:0] load_count,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [BUF_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    logic             r_valid;
    logic [BUF_W-1:0] r_data;
    logic [CNT_W-1:0] r_count;

    // The packer only asserts load when this register is free, so a load
    // may coincide with a handshake and simply replaces the departing frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
            r_count <= load_count;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_count = r_count;

endmodule
`default_nettype wire

// File: rtl/nios2_cordic_cpu_oci_dct_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nios2_cordic_cpu_oci_dct_ctrl
// Brief    : Packs trace atoms into the DCT buffer and sequences flush/end
// Revision : 1.0 - initial release
// ============================================================================
module nios2_cordic_cpu_oci_dct_ctrl
    import nios2_cordic_cpu_oci_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom_data,
    input  logic              flush_req,
    input  logic              end_req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BUF_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              test_ending,
    output logic              test_has_ended,
    output logic              overflow,
    output logic [OVF_W-1:0]  drop_count
);

    dct_state_t       r_state;
    dct_state_t       w_next_state;
    logic [BUF_W-1:0] r_buffer;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic [OVF_W-1:0] r_drop_count;

    logic w_hold_free;
    logic w_flushing;
    logic w_full;
    logic w_empty;
    logic w_packing;
    logic w_xfer;
    logic w_accept;
    logic w_drop;

    assign w_hold_free = !out_valid || out_ready;
    assign w_flushing  = (r_state == FLUSH) || (r_state == END_FLUSH);
    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_packing   = (r_state == RUN) || (r_state == FLUSH);
    assign w_xfer      = w_hold_free && (w_full || (w_flushing && !w_empty));
    // A full buffer only takes a new atom when it is emptied on the same edge.
    assign w_accept    = w_packing && atom_valid && (!w_full || w_xfer);
    assign w_drop      = w_packing && atom_valid && w_full && !w_xfer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A flush arriving while a full-buffer transfer fires is satisfied by it.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            RUN: begin
                if (end_req) begin
                    w_next_state = END_FLUSH;
                end else if (flush_req && !w_xfer) begin
                    w_next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (end_req) begin
                    w_next_state = END_FLUSH;
                end else if (w_xfer || w_empty) begin
                    w_next_state = RUN;
                end
            end
            END_FLUSH: begin
                if (w_empty && !out_valid) begin
                    w_next_state = ENDED;
                end
            end
            ENDED: begin
                w_next_state = ENDED;
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    always_comb begin
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        unique case (r_state)
            END_FLUSH: test_ending    = 1'b1;
            ENDED:     test_has_ended = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buffer <= '0;
            r_count  <= '0;
        end else if (w_xfer) begin
            r_buffer <= w_accept ? {{(BUF_W-ATOM_W){1'b0}}, atom_data} : '0;
            r_count  <= w_accept ? CNT_W'(1) : '0;
        end else if (w_accept) begin
            r_buffer <= {r_buffer[BUF_W-ATOM_W-1:0], atom_data};
            r_count  <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != DROP_MAX) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    nios2_cordic_cpu_oci_dct_hold u_hold (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (w_xfer),
        .load_data  (r_buffer),
        .load_count (r_count),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_count  (out_count)
    );

    assign dct_buffer = r_buffer;
    assign dct_count  = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire
